// File: rtl/af_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : af_sweep_ctrl
// Purpose  : Autofocus coarse-sweep scheduler. Steps the VCM through lens
//            positions 0, COARSE_STEP, 2*COARSE_STEP ... up to MAX_POS. At
//            each point it waits SETTLE_FRAMES frame ends, samples one
//            sharpness sum and tracks the sharpest position. At the end of the
//            sweep it commands the VCM to the best position found.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   VIDEO_CLK  in   1       sole clock
//   RESET      in   1       synchronous active-high reset
//   START      in   1       pulse, begins a sweep when idle
//   FRAME_END  in   1       pulse, SHARP valid in this cycle
//   SHARP      in   SUM_W   sharpness sum of the frame just ended
//   WR_REQ     out  1       VCM write request (registered)
//   WR_POS     out  STEP_W  requested position, stable while WR_REQ=1
//   WR_ACK     in   1       writer accepted WR_POS
//   BUSY       out  1       sweep in progress
//   DONE       out  1       pulse once the final move is acknowledged
//   BEST_POS   out  STEP_W  best position of last completed/running sweep
//   STATE      out  3       state code for status LEDs
// ============================================================================
module af_sweep_ctrl #(
  parameter int STEP_W        = 10,
  parameter int SUM_W         = 24,
  parameter int COARSE_STEP   = 32,
  parameter int MAX_POS       = 1023,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              FRAME_END,
  input  logic [SUM_W-1:0]  SHARP,
  output logic              WR_REQ,
  output logic [STEP_W-1:0] WR_POS,
  input  logic              WR_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic [STEP_W-1:0] BEST_POS,
  output logic [2:0]        STATE
);

  localparam int                c_CNT_W    = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [STEP_W:0]   c_STEP     = (STEP_W+1)'(COARSE_STEP);
  localparam logic [STEP_W:0]   c_MAX      = (STEP_W+1)'(MAX_POS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MOVE     = 3'd1,
    S_SETTLE   = 3'd2,
    S_MEASURE  = 3'd3,
    S_EVAL     = 3'd4,
    S_FINAL    = 3'd5,
    S_FIN_WAIT = 3'd6
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [STEP_W-1:0]   r_pos,        w_pos_nxt;
  logic [SUM_W-1:0]    r_cur,        w_cur_nxt;
  logic [SUM_W-1:0]    r_best_sharp, w_best_sharp_nxt;
  logic [STEP_W-1:0]   r_best_pos,   w_best_pos_nxt;
  logic [c_CNT_W-1:0]  r_cnt,        w_cnt_nxt;
  logic                r_wr_req,     w_wr_req_nxt;
  logic [STEP_W-1:0]   r_wr_pos,     w_wr_pos_nxt;
  logic                r_busy,       w_busy_nxt;
  logic                r_done,       w_done_nxt;

  // Next sweep point is one bit wider so overflow past MAX_POS is visible.
  logic [STEP_W:0]     w_next_pos;
  logic                w_better;
  logic                w_early;

  assign w_next_pos = {1'b0, r_pos} + c_STEP;
  assign w_better   = (r_cur > r_best_sharp);
  // Early exit: sharpness dropped below 75% of the pre-update peak.
  assign w_early    = (r_best_sharp != '0) &&
                      (r_cur < (r_best_sharp - (r_best_sharp >> 2)));

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_cur_nxt        = r_cur;
    w_best_sharp_nxt = r_best_sharp;
    w_best_pos_nxt   = r_best_pos;
    w_cnt_nxt        = r_cnt;
    w_wr_req_nxt     = r_wr_req;
    w_wr_pos_nxt     = r_wr_pos;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_best_sharp_nxt = '0;
          w_best_pos_nxt   = '0;
          w_pos_nxt        = '0;
          w_wr_req_nxt     = 1'b1;
          w_wr_pos_nxt     = '0;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = S_MOVE;
        end
      end
      S_MOVE: begin
        // WR_REQ is always high in this state, so any ACK here is valid.
        if (WR_ACK) begin
          w_wr_req_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = (SETTLE_FRAMES == 0) ? S_MEASURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (FRAME_END) begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_MEASURE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (FRAME_END) begin
          w_cur_nxt   = SHARP;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_better) begin
          w_best_sharp_nxt = r_cur;
          w_best_pos_nxt   = r_pos;
        end
        w_wr_req_nxt = 1'b1;
        if (w_early || (w_next_pos > c_MAX)) begin
          // The final target must include a best update made this cycle.
          w_wr_pos_nxt = w_better ? r_pos : r_best_pos;
          w_state_nxt  = S_FINAL;
        end else begin
          w_pos_nxt    = w_next_pos[STEP_W-1:0];
          w_wr_pos_nxt = w_next_pos[STEP_W-1:0];
          w_state_nxt  = S_MOVE;
        end
      end
      S_FINAL: begin
        if (WR_ACK) begin
          w_wr_req_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = S_FIN_WAIT;
        end
      end
      S_FIN_WAIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_wr_req_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_pos        <= '0;
      r_cur        <= '0;
      r_best_sharp <= '0;
      r_best_pos   <= '0;
      r_cnt        <= '0;
      r_wr_req     <= 1'b0;
      r_wr_pos     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_cur        <= w_cur_nxt;
      r_best_sharp <= w_best_sharp_nxt;
      r_best_pos   <= w_best_pos_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wr_req     <= w_wr_req_nxt;
      r_wr_pos     <= w_wr_pos_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign WR_REQ   = r_wr_req;
  assign WR_POS   = r_wr_pos;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign BEST_POS = r_best_pos;
  assign STATE    = r_state;

endmodule
`default_nettype wire
